sc_ulpi_rxp: RTL and testbench

SC_ULPI_RXP -- requirements
Module: sc_ulpi_rxp

---
 rtl/sc_ulpi_pkg.sv | 28 ++
 rtl/sc_ulpi_rxp_if.sv | 34 +++
 rtl/sc_ulpi_rxp_fifo.sv | 48 ++++
 rtl/sc_ulpi_rxp.sv | 132 +++++++++++++
 tb/tb_sc_ulpi_rxp.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_ulpi_pkg.sv
// sc_ulpi_pkg: shared ULPI constants, RX CMD field positions and the RX packet FIFO entry type.
//   No ports; imported by the ULPI receive path modules.
package sc_ulpi_pkg;

    localparam logic [1:0] RX_EV_INACTIVE  = 2'b00;
    localparam logic [1:0] RX_EV_ACTIVE    = 2'b01;
    localparam logic [1:0] RX_EV_HOST_DISC = 2'b10;
    localparam logic [1:0] RX_EV_ERROR     = 2'b11;

    localparam int RXCMD_LS_LSB   = 0;
    localparam int RXCMD_VBUS_LSB = 2;
    localparam int RXCMD_EV_LSB   = 4;
    localparam int RXCMD_ID_BIT   = 6;
    localparam int RXCMD_ALT_BIT  = 7;

    localparam int RXP_ENTRY_W = 10;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } rxp_entry_t;

    function automatic logic [1:0] rx_event(input logic [7:0] cmd);
        return cmd[RXCMD_EV_LSB +: 2];
    endfunction

endpackage

// File: rtl/sc_ulpi_rxp_if.sv
// sc_ulpi_rxp_if: bundle between the ULPI protocol engine, the RX packetiser and its consumer.
//   RXD_CMD_VALID/RXD_DATA_VALID/ULPI_DATA : strobes and byte from the protocol engine
//   RXP_VALID/RXP_READY/RXP_DATA/RXP_LAST/RXP_ERR : packet-byte stream
//   LINE_STATE/VBUS_STATE/ID_DIG/ALT_INT/RX_ACTIVE/HOST_DISC/DROP_CNT : status
//   slave = packetiser side, master = engine/consumer side.
interface sc_ulpi_rxp_if;
    logic       RXD_CMD_VALID;
    logic       RXD_DATA_VALID;
    logic [7:0] ULPI_DATA;
    logic       RXP_VALID;
    logic       RXP_READY;
    logic [7:0] RXP_DATA;
    logic       RXP_LAST;
    logic       RXP_ERR;
    logic [1:0] LINE_STATE;
    logic [1:0] VBUS_STATE;
    logic       ID_DIG;
    logic       ALT_INT;
    logic       RX_ACTIVE;
    logic       HOST_DISC;
    logic [7:0] DROP_CNT;

    modport slave (
        input  RXD_CMD_VALID, RXD_DATA_VALID, ULPI_DATA, RXP_READY,
        output RXP_VALID, RXP_DATA, RXP_LAST, RXP_ERR, LINE_STATE, VBUS_STATE,
               ID_DIG, ALT_INT, RX_ACTIVE, HOST_DISC, DROP_CNT
    );

    modport master (
        output RXD_CMD_VALID, RXD_DATA_VALID, ULPI_DATA, RXP_READY,
        input  RXP_VALID, RXP_DATA, RXP_LAST, RXP_ERR, LINE_STATE, VBUS_STATE,
               ID_DIG, ALT_INT, RX_ACTIVE, HOST_DISC, DROP_CNT
    );
endinterface

// File: rtl/sc_ulpi_rxp_fifo.sv
// sc_ulpi_rxp_fifo: DEPTH-entry FIFO of {err,last,data} with a registered head output.
//   ULPICLK/ULPIRST : clock, sync active-high reset
//   push/wdata/full : write side; push allowed while full only together with a pop
//   vld/rdy/dout    : read side valid/ready handshake, dout stable while vld && !rdy
module sc_ulpi_rxp_fifo
    import sc_ulpi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   ULPICLK,
    input  logic                   ULPIRST,
    input  logic                   push,
    input  logic [RXP_ENTRY_W-1:0] wdata,
    output logic                   full,
    input  logic                   rdy,
    output logic                   vld,
    output logic [RXP_ENTRY_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [RXP_ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr, rd_nxt;
    logic                   pop;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = vld & rdy;
    assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};

    always_ff @(posedge ULPICLK)
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;

    // The head entry stays in mem until popped so it counts toward DEPTH; dout is a
    // registered copy of it, loaded the cycle after the entry was written.
    always_ff @(posedge ULPICLK)
        if (ULPIRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
            rd_ptr <= rd_nxt;
            if (!vld || pop) begin
                vld <= wr_ptr != rd_nxt;
                if (wr_ptr != rd_nxt) dout <= mem[rd_nxt[AW-1:0]];
            end
        end
endmodule

// File: rtl/sc_ulpi_rxp.sv
// sc_ulpi_rxp: turns ULPI RX CMD/data strobes into a packet-byte stream with LAST/ERR and line status.
//   ULPICLK/ULPIRST : clock, sync active-high reset
//   bus (slave)     : engine strobes in, RXP_* stream out, status and drop counter out
module sc_ulpi_rxp
    import sc_ulpi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic         ULPICLK,
    input logic         ULPIRST,
    sc_ulpi_rxp_if.slave bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_EOP_PEND = 2'd2;

    logic [1:0] state, ev, line_state, vbus_state;
    logic [7:0] stg_data, drop_cnt;
    logic       stg_vld, err_flag, pend_start, pend_err, id_dig, alt_int, host_disc;
    logic       cmd, dat, ev_start, ev_err, pop, can_push, eop_now, push_last, push_mid, drop;
    logic       ps_n, pe_n, fifo_full, fifo_vld;
    rxp_entry_t push_data, out_e;

    assign cmd      = bus.RXD_CMD_VALID;
    assign dat      = bus.RXD_DATA_VALID & ~cmd;
    assign ev       = rx_event(bus.ULPI_DATA);
    assign ev_start = (ev == RX_EV_ACTIVE) || (ev == RX_EV_ERROR);
    assign ev_err   = ev == RX_EV_ERROR;
    assign pop      = fifo_vld & bus.RXP_READY;
    assign can_push = ~fifo_full | pop;

    assign eop_now   = (state == S_ACTIVE) && cmd && !ev_start;
    assign push_last = stg_vld && can_push && (eop_now || state == S_EOP_PEND);
    assign push_mid  = (state == S_ACTIVE) && dat && stg_vld && can_push;
    assign push_data = '{err: push_last & err_flag, last: push_last, data: stg_data};
    // A data byte colliding with an RX CMD is lost as well as ones that find no room.
    assign drop = (cmd & bus.RXD_DATA_VALID) |
                  (dat && (state == S_EOP_PEND || (state == S_ACTIVE && stg_vld && !can_push)));

    // While waiting to push the final byte, the latest RX CMD decides whether a new packet follows.
    assign ps_n = cmd ? ev_start : pend_start;
    assign pe_n = cmd ? (ev_err | (pend_err & ev_start)) : pend_err;

    always_ff @(posedge ULPICLK)
        if (ULPIRST) begin
            state      <= S_IDLE;
            stg_vld    <= 1'b0;
            stg_data   <= '0;
            err_flag   <= 1'b0;
            pend_start <= 1'b0;
            pend_err   <= 1'b0;
            drop_cnt   <= '0;
            line_state <= '0;
            vbus_state <= '0;
            id_dig     <= 1'b0;
            alt_int    <= 1'b0;
            host_disc  <= 1'b0;
        end else begin
            if (cmd) begin
                line_state <= bus.ULPI_DATA[RXCMD_LS_LSB +: 2];
                vbus_state <= bus.ULPI_DATA[RXCMD_VBUS_LSB +: 2];
                id_dig     <= bus.ULPI_DATA[RXCMD_ID_BIT];
                alt_int    <= bus.ULPI_DATA[RXCMD_ALT_BIT];
            end
            host_disc <= cmd && (ev == RX_EV_HOST_DISC);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            case (state)
                S_IDLE:
                    if (cmd && ev_start) begin
                        state    <= S_ACTIVE;
                        err_flag <= ev_err;
                    end else if (dat) begin
                        state    <= S_ACTIVE;
                        err_flag <= 1'b0;
                        stg_data <= bus.ULPI_DATA;
                        stg_vld  <= 1'b1;
                    end
                S_ACTIVE:
                    if (cmd) begin
                        if (ev_start) err_flag <= err_flag | ev_err;
                        else if (!stg_vld || can_push) begin
                            stg_vld <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            state      <= S_EOP_PEND;
                            pend_start <= 1'b0;
                            pend_err   <= 1'b0;
                        end
                    end else if (dat) begin
                        if (!stg_vld || can_push) begin
                            stg_data <= bus.ULPI_DATA;
                            stg_vld  <= 1'b1;
                        end else err_flag <= 1'b1;
                    end
                S_EOP_PEND:
                    if (can_push) begin
                        stg_vld    <= 1'b0;
                        state      <= ps_n ? S_ACTIVE : S_IDLE;
                        err_flag   <= pe_n;
                        pend_start <= 1'b0;
                        pend_err   <= 1'b0;
                    end else begin
                        pend_start <= ps_n;
                        pend_err   <= pe_n;
                    end
                default: state <= S_IDLE;
            endcase
        end

    sc_ulpi_rxp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .ULPICLK (ULPICLK),
        .ULPIRST (ULPIRST),
        .push    (push_last | push_mid),
        .wdata   (push_data),
        .full    (fifo_full),
        .rdy     (bus.RXP_READY),
        .vld     (fifo_vld),
        .dout    (out_e)
    );

    assign bus.RXP_VALID  = fifo_vld;
    assign bus.RXP_DATA   = out_e.data;
    assign bus.RXP_LAST   = out_e.last;
    assign bus.RXP_ERR    = out_e.err;
    assign bus.LINE_STATE = line_state;
    assign bus.VBUS_STATE = vbus_state;
    assign bus.ID_DIG     = id_dig;
    assign bus.ALT_INT    = alt_int;
    assign bus.RX_ACTIVE  = state == S_ACTIVE;
    assign bus.HOST_DISC  = host_disc;
    assign bus.DROP_CNT   = drop_cnt;
endmodule

// File: tb/tb_sc_ulpi_rxp.sv
// tb_sc_ulpi_rxp: directed self-checking bench for sc_ulpi_rxp (DEPTH=16).
module tb_sc_ulpi_rxp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] q[$];

    sc_ulpi_rxp_if bus();

    sc_ulpi_rxp #(.DEPTH(16)) dut (
        .ULPICLK (clk),
        .ULPIRST (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so at negedge a VALID&&READY pair is a pop at the next edge.
    always @(negedge clk)
        if (!rst && bus.RXP_VALID && bus.RXP_READY)
            q.push_back({bus.RXP_ERR, bus.RXP_LAST, bus.RXP_DATA});

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic c, input logic d, input logic [7:0] b);
        bus.RXD_CMD_VALID  = c;
        bus.RXD_DATA_VALID = d;
        bus.ULPI_DATA      = b;
        step(1);
        bus.RXD_CMD_VALID  = 1'b0;
        bus.RXD_DATA_VALID = 1'b0;
    endtask

    task automatic test_reset;
        bus.RXD_CMD_VALID  = 1'b0;
        bus.RXD_DATA_VALID = 1'b0;
        bus.ULPI_DATA      = 8'h00;
        bus.RXP_READY      = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        checks++;
        if ({bus.RXP_VALID, bus.RXP_LAST, bus.RXP_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {bus.RXP_VALID, bus.RXP_LAST, bus.RXP_ERR});
        end
        checks++;
        if (bus.RXP_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h exp 00", bus.RXP_DATA);
        end
        checks++;
        if ({bus.LINE_STATE, bus.VBUS_STATE, bus.ID_DIG, bus.ALT_INT} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status got %b exp 000000", {bus.LINE_STATE, bus.VBUS_STATE, bus.ID_DIG, bus.ALT_INT});
        end
        checks++;
        if ({bus.RX_ACTIVE, bus.HOST_DISC} !== 2'b00) begin
            errors++;
            $display("FAIL reset_active got %b exp 00", {bus.RX_ACTIVE, bus.HOST_DISC});
        end
        checks++;
        if (bus.DROP_CNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop got %0d exp 0", bus.DROP_CNT);
        end
    endtask

    task automatic test_basic;
        logic [9:0] exp_q [3];
        exp_q = '{10'h0C3, 10'h001, 10'h102};
        bus.RXP_READY = 1'b1;
        q.delete();
        strobe(1'b1, 1'b0, 8'h1D);
        checks++;
        if ({bus.LINE_STATE, bus.VBUS_STATE, bus.RX_ACTIVE} !== 5'b01111) begin
            errors++;
            $display("FAIL basic_start got %b exp 01111", {bus.LINE_STATE, bus.VBUS_STATE, bus.RX_ACTIVE});
        end
        strobe(1'b0, 1'b1, 8'hC3);
        checks++;
        if ({bus.LINE_STATE, bus.VBUS_STATE, bus.RX_ACTIVE} !== 5'b01111) begin
            errors++;
            $display("FAIL basic_data_no_status got %b exp 01111", {bus.LINE_STATE, bus.VBUS_STATE, bus.RX_ACTIVE});
        end
        strobe(1'b0, 1'b1, 8'h01);
        checks++;
        if (bus.RXP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency got %b exp 0", bus.RXP_VALID);
        end
        strobe(1'b0, 1'b1, 8'h02);
        checks++;
        if ({bus.RXP_VALID, bus.RXP_DATA} !== {1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL basic_first got %h exp 1c3", {bus.RXP_VALID, bus.RXP_DATA});
        end
        strobe(1'b1, 1'b0, 8'h0D);
        step(4);
        checks++;
        if (q.size() !== 3) begin
            errors++;
            $display("FAIL basic_count got %0d exp 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_byte%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
        checks++;
        if ({bus.LINE_STATE, bus.VBUS_STATE, bus.RX_ACTIVE} !== 5'b01110) begin
            errors++;
            $display("FAIL basic_end got %b exp 01110", {bus.LINE_STATE, bus.VBUS_STATE, bus.RX_ACTIVE});
        end
    endtask

    task automatic test_error;
        logic [9:0] exp_q [2];
        exp_q = '{10'h0AA, 10'h3BB};
        q.delete();
        strobe(1'b1, 1'b0, 8'h11);
        strobe(1'b0, 1'b1, 8'hAA);
        strobe(1'b0, 1'b1, 8'hBB);
        strobe(1'b1, 1'b0, 8'h31);
        strobe(1'b1, 1'b0, 8'h01);
        step(4);
        checks++;
        if (q.size() !== 2) begin
            errors++;
            $display("FAIL err_count got %0d exp 2", q.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL err_byte%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [9:0] exp_e;
        bus.RXP_READY = 1'b0;
        q.delete();
        for (int i = 1; i <= 20; i++) strobe(1'b0, 1'b1, 8'h40 + 8'(i));
        strobe(1'b1, 1'b0, 8'h00);
        checks++;
        if ({bus.RX_ACTIVE, bus.DROP_CNT} !== {1'b0, 8'd3}) begin
            errors++;
            $display("FAIL ovf_drop got %h exp 003", {bus.RX_ACTIVE, bus.DROP_CNT});
        end
        checks++;
        if ({bus.RXP_VALID, bus.RXP_LAST, bus.RXP_DATA} !== {2'b10, 8'h41}) begin
            errors++;
            $display("FAIL ovf_head got %h exp 241", {bus.RXP_VALID, bus.RXP_LAST, bus.RXP_DATA});
        end
        strobe(1'b0, 1'b1, 8'hEE);
        checks++;
        if (bus.DROP_CNT !== 8'd4) begin
            errors++;
            $display("FAIL ovf_pend_drop got %0d exp 4", bus.DROP_CNT);
        end
        bus.RXP_READY = 1'b1;
        step(25);
        checks++;
        if (q.size() !== 17) begin
            errors++;
            $display("FAIL ovf_count got %0d exp 17", q.size());
        end
        for (int i = 0; i < 17; i++) begin
            exp_e = (i == 16) ? 10'h351 : {2'b00, 8'h41 + 8'(i)};
            checks++;
            if (q[i] !== exp_e) begin
                errors++;
                $display("FAIL ovf_byte%0d got %h exp %h", i, q[i], exp_e);
            end
        end
        checks++;
        if ({bus.RXP_VALID, bus.RX_ACTIVE} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_idle got %b exp 00", {bus.RXP_VALID, bus.RX_ACTIVE});
        end
    endtask

    task automatic test_zero_len;
        logic all_hi;
        q.delete();
        strobe(1'b1, 1'b0, 8'h10);
        all_hi = bus.RX_ACTIVE;
        for (int i = 0; i < 3; i++) begin
            step(1);
            all_hi &= bus.RX_ACTIVE;
        end
        checks++;
        if (all_hi !== 1'b1) begin
            errors++;
            $display("FAIL zl_active got %b exp 1", all_hi);
        end
        strobe(1'b1, 1'b0, 8'h00);
        checks++;
        if (bus.RX_ACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL zl_inactive got %b exp 0", bus.RX_ACTIVE);
        end
        step(4);
        checks++;
        if (q.size() !== 0 || bus.RXP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL zl_no_output got %0d/%b exp 0/0", q.size(), bus.RXP_VALID);
        end
    endtask

    task automatic test_host_disc_sat;
        strobe(1'b1, 1'b0, 8'hC0);
        checks++;
        if ({bus.ID_DIG, bus.ALT_INT, bus.HOST_DISC} !== 3'b110) begin
            errors++;
            $display("FAIL hd_id_alt got %b exp 110", {bus.ID_DIG, bus.ALT_INT, bus.HOST_DISC});
        end
        strobe(1'b1, 1'b0, 8'h20);
        checks++;
        if ({bus.HOST_DISC, bus.RX_ACTIVE} !== 2'b10) begin
            errors++;
            $display("FAIL hd_pulse got %b exp 10", {bus.HOST_DISC, bus.RX_ACTIVE});
        end
        step(1);
        checks++;
        if (bus.HOST_DISC !== 1'b0) begin
            errors++;
            $display("FAIL hd_pulse_end got %b exp 0", bus.HOST_DISC);
        end
        for (int i = 0; i < 250; i++) strobe(1'b1, 1'b1, 8'h00);
        checks++;
        if (bus.DROP_CNT !== 8'd254) begin
            errors++;
            $display("FAIL sat_254 got %0d exp 254", bus.DROP_CNT);
        end
        for (int i = 0; i < 50; i++) strobe(1'b1, 1'b1, 8'h00);
        checks++;
        if (bus.DROP_CNT !== 8'd255) begin
            errors++;
            $display("FAIL sat_255 got %0d exp 255", bus.DROP_CNT);
        end
    endtask

    task automatic test_reset_mid;
        q.delete();
        strobe(1'b0, 1'b1, 8'h11);
        strobe(1'b0, 1'b1, 8'h22);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if ({bus.RXP_VALID, bus.RXP_DATA, bus.RXP_LAST, bus.RXP_ERR, bus.LINE_STATE, bus.VBUS_STATE,
             bus.ID_DIG, bus.ALT_INT, bus.RX_ACTIVE, bus.HOST_DISC, bus.DROP_CNT} !== 27'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h exp 0", {bus.RXP_VALID, bus.RXP_DATA, bus.RXP_LAST, bus.RXP_ERR,
                     bus.LINE_STATE, bus.VBUS_STATE, bus.ID_DIG, bus.ALT_INT, bus.RX_ACTIVE, bus.HOST_DISC, bus.DROP_CNT});
        end
        strobe(1'b0, 1'b1, 8'h5A);
        strobe(1'b1, 1'b0, 8'h00);
        step(4);
        checks++;
        if (q.size() !== 1) begin
            errors++;
            $display("FAIL rstmid_count got %0d exp 1", q.size());
        end
        checks++;
        if (q[0] !== 10'h15A) begin
            errors++;
            $display("FAIL rstmid_byte got %h exp 15a", q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_overflow();
        test_zero_len();
        test_host_disc_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
